i2c_cmd_master: RTL and testbench
=================================

Name: i2c_cmd_master

Overview:
- Write-only I2C bus master that executes the packed 37-bit commands issued by the Si570/mux controller (`i2ccmd`, `i2cstart`) and returns `i2cbusy`.
- Each command is serialised onto an open-drain SCL/SDA pair as START, 1–4 bytes, STOP.
- Sits between the frequency-control logic and the IOB tristate buffers for the board I2C bus.
- Supports slave clock stretching and reports NACK.

Parameters:
- CLKDIV, 16'd250: clk cycles per quarter SCL period (250 at 100 MHz gives 100 kHz); legal range 2..65535.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- i2ccmd  input  37  [36] valid, [35:32] byte count n incl. address byte, [31:24] byte0 {addr7,rw}, [23:16] byte1, [15:8] byte2, [7:0] byte3
- i2cstart  input  1  single-cycle command strobe
- i2cbusy  output  1  command in progress
- done  output  1  one-cycle pulse when a command finishes (normal or aborted)
- nack  output  1  sticky: last command was aborted on NACK; cleared on next accepted command
- cmd_err  output  1  one-cycle pulse when a strobed command is rejected
- scl_oe  output  1  1 = drive SCL low; 0 = release
- sda_oe  output  1  1 = drive SDA low; 0 = release
- scl_in  input  1  sampled SCL pad (clock stretching)
- sda_in  input  1  sampled SDA pad (ACK)

Behaviour:
- Reset (async assert, sync release): all outputs are 0; the bus is released; state is IDLE; the quarter counter is 0.
- Accept rules:
  - A command is accepted when `i2cstart`=1 in IDLE with `i2ccmd[36]`=1 and 1<=n<=4.
  - On acceptance, latch `i2ccmd` into a shift register, clear `nack`, and set `i2cbusy`=1 on the next cycle.
  - If `i2cstart`=1 in IDLE with `i2ccmd[36]`=0, or n=0, or n>4: pulse `cmd_err` next cycle, no bus activity, `i2cbusy` stays 0.
  - `i2cstart` while busy is ignored; `cmd_err` is not pulsed.
- Timing base:
  - A divider produces a tick every CLKDIV cycles.
  - All bus edges occur on ticks ("quarters").
  - The divider restarts at 0 on acceptance.
- States: IDLE, START, BIT, ACK, STOP, BUSFREE.
  - START (2 quarters): q0 sda_oe=1 with SCL released; q1 scl_oe=1.
  - BIT (4 quarters per bit, MSB first, 8 bits):
    - q0 drives the data bit with `sda_oe`=~bit.
    - q1 releases SCL.
    - q2 holds SCL high.
    - q3 sets scl_oe=1.
  - ACK (4 quarters): SDA is released, otherwise identical to BIT; `sda_in` is sampled at the end of q2.
    - 0 means ACK: next byte, or STOP after byte n-1.
    - 1 means NACK: set `nack`=1 and go to STOP.
  - STOP (3 quarters): q0 sda_oe=1; q1 release SCL; q2 release SDA.
  - BUSFREE (4 quarters): bus idle. At its end, `i2cbusy` goes to 0 and `done` pulses in the same cycle; return to IDLE.
- Clock stretching: in any quarter where SCL is released, the tick counter holds while `scl_in`=0 after release. Timing resumes when `scl_in`=1.
- Duration with no stretching and no NACK: (36n+9)·CLKDIV cycles from the first busy cycle to `i2cbusy` falling.
- NACK on byte k (0-based): the duration is (36(k+1)+9)·CLKDIV cycles, and remaining bytes are not sent.
- The rw bit is transmitted as given; the block never reads. With rw=1 it still drives the remaining bytes, which is legal only for n=1 (address probe).
- Byte shifting: the shift register shifts left by 1 at each BIT q3; the byte counter counts down from n.
- Reset mid-command: the bus is released immediately (asynchronously). No STOP is generated and no `done` pulse is issued.

Test Plan:
- CLKDIV=4, cmd {1,4'h3,7'h5d,0,8'd135,8'h20,8'h0}, ACK all → SDA bytes 0xBA,0x87,0x20, 27 SCL high pulses, `i2cbusy` high exactly 468 cycles, `done` pulse, `nack`=0.
- CLKDIV=4, mux cmd {1,4'h2,7'h74,0,8'h01,16'h0} → bytes 0xE8,0x01, 18 SCL pulses, busy 324 cycles.
- Slave NACKs byte 1 of a 3-byte command → `nack`=1, STOP after the 2nd ACK slot, busy 324 cycles. A following good command clears `nack`.
- Slave holds SCL low for 50 cycles after the 3rd bit's release → busy extends by exactly 50 cycles, and bit values are unchanged.
- Strobes with n=0, n=5, and valid=0 → `cmd_err` pulse each time, `scl_oe`=`sda_oe`=0 throughout, `i2cbusy`=0. A second strobe during an active command is ignored.
- Assert rstn=0 mid-byte → `scl_oe`, `sda_oe`, and `i2cbusy` go to 0 immediately. After release, a new command completes normally.

Source files
------------

// File: rtl/i2c_cmd_master_if.sv
// ============================================================================
// i2c_cmd_master_if : command handshake and open-drain I2C pad bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface i2c_cmd_master_if;
  logic [36:0] i2ccmd;
  logic        i2cstart;
  logic        i2cbusy;
  logic        done;
  logic        nack;
  logic        cmd_err;
  logic        scl_oe;
  logic        sda_oe;
  logic        scl_in;
  logic        sda_in;

  modport master (
    input  i2ccmd, i2cstart, scl_in, sda_in,
    output i2cbusy, done, nack, cmd_err, scl_oe, sda_oe
  );

  modport slave (
    output i2ccmd, i2cstart, scl_in, sda_in,
    input  i2cbusy, done, nack, cmd_err, scl_oe, sda_oe
  );
endinterface

`default_nettype wire

// File: rtl/i2c_cmd_master.sv
// ============================================================================
// i2c_cmd_master : write-only I2C master serialising packed 1..4 byte commands
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_cmd_master #(
  parameter logic [15:0] CLKDIV = 16'd250
) (
  input  logic              clk,
  input  logic              rstn,
  i2c_cmd_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_BIT     = 3'd2,
    S_ACK     = 3'd3,
    S_STOP    = 3'd4,
    S_BUSFREE = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_quarter;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_byte_cnt;
  logic [31:0] r_shreg;
  logic [15:0] r_qcnt;
  logic        r_ack_fail;

  logic [3:0]  w_n;
  logic        w_cmd_ok;
  logic        w_hold;
  logic        w_tick;

  assign w_n      = bus.i2ccmd[35:32];
  assign w_cmd_ok = bus.i2ccmd[36] && (w_n != 4'd0) && (w_n <= 4'd4);
  // A released SCL still reading low means a slave is stretching the clock.
  assign w_hold   = (r_state != S_IDLE) && !bus.scl_oe && !bus.scl_in;
  assign w_tick   = (r_qcnt == CLKDIV - 16'd1) && !w_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_quarter    <= 2'd0;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 3'd0;
      r_shreg      <= 32'd0;
      r_qcnt       <= 16'd0;
      r_ack_fail   <= 1'b0;
      bus.i2cbusy  <= 1'b0;
      bus.done     <= 1'b0;
      bus.nack     <= 1'b0;
      bus.cmd_err  <= 1'b0;
      bus.scl_oe   <= 1'b0;
      bus.sda_oe   <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.cmd_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt    <= 16'd0;
        r_quarter <= 2'd0;
        if (bus.i2cstart) begin
          if (w_cmd_ok) begin
            r_shreg     <= bus.i2ccmd[31:0];
            r_byte_cnt  <= w_n[2:0];
            r_bit_cnt   <= 3'd0;
            r_ack_fail  <= 1'b0;
            bus.nack    <= 1'b0;
            bus.i2cbusy <= 1'b1;
            bus.sda_oe  <= 1'b1;
            r_state     <= S_START;
          end else begin
            bus.cmd_err <= 1'b1;
          end
        end
      end else begin
        if (!w_hold)
          r_qcnt <= w_tick ? 16'd0 : r_qcnt + 16'd1;
        if (w_tick) begin
          r_quarter <= r_quarter + 2'd1;
          // Outputs below are those of the quarter being entered.
          case (r_state)
            S_START: begin
              if (r_quarter == 2'd0) begin
                bus.scl_oe <= 1'b1;
              end else begin
                r_state    <= S_BIT;
                r_quarter  <= 2'd0;
                bus.sda_oe <= ~r_shreg[31];
              end
            end
            S_BIT: begin
              case (r_quarter)
                2'd0: bus.scl_oe <= 1'b0;
                2'd2: bus.scl_oe <= 1'b1;
                2'd3: begin
                  r_shreg   <= {r_shreg[30:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                    r_state    <= S_ACK;
                    bus.sda_oe <= 1'b0;
                  end else begin
                    bus.sda_oe <= ~r_shreg[30];
                  end
                end
                default: ;
              endcase
            end
            S_ACK: begin
              case (r_quarter)
                2'd0: bus.scl_oe <= 1'b0;
                2'd2: begin
                  r_ack_fail <= bus.sda_in;
                  if (bus.sda_in)
                    bus.nack <= 1'b1;
                  bus.scl_oe <= 1'b1;
                end
                2'd3: begin
                  if (r_ack_fail || (r_byte_cnt == 3'd1)) begin
                    r_state    <= S_STOP;
                    bus.sda_oe <= 1'b1;
                  end else begin
                    r_byte_cnt <= r_byte_cnt - 3'd1;
                    r_state    <= S_BIT;
                    bus.sda_oe <= ~r_shreg[31];
                  end
                end
                default: ;
              endcase
            end
            S_STOP: begin
              case (r_quarter)
                2'd0: bus.scl_oe <= 1'b0;
                2'd1: bus.sda_oe <= 1'b0;
                2'd2: begin
                  r_state   <= S_BUSFREE;
                  r_quarter <= 2'd0;
                end
                default: ;
              endcase
            end
            S_BUSFREE: begin
              if (r_quarter == 2'd3) begin
                r_state     <= S_IDLE;
                bus.i2cbusy <= 1'b0;
                bus.done    <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_master.sv
// ============================================================================
// tb_i2c_cmd_master : directed self-checking bench with a simple I2C slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_cmd_master;

  logic clk;
  logic rstn;

  i2c_cmd_master_if bus ();

  i2c_cmd_master #(.CLKDIV(16'd4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // slave / bus monitor state
  logic [7:0] rx [0:7];
  int         rx_n;
  int         pulses;
  int         bit_idx;
  logic [7:0] sh;
  logic       seen_rise;
  logic       ack_en;
  logic       prev_scl;
  logic       prev_oe;
  int         oe_falls;
  int         stretch_left;
  logic       stretch_arm;
  int         nack_byte;
  int         err_cnt;
  logic       scl_now;
  logic       sda_now;

  assign bus.scl_in = ~bus.scl_oe & (stretch_left == 0);
  assign bus.sda_in = ~bus.sda_oe & ~ack_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int nk, input logic arm);
    rx_n         = 0;
    pulses       = 0;
    bit_idx      = 0;
    sh           = 8'd0;
    seen_rise    = 1'b0;
    ack_en       = 1'b0;
    prev_scl     = 1'b1;
    prev_oe      = 1'b0;
    oe_falls     = 0;
    stretch_left = 0;
    stretch_arm  = arm;
    nack_byte    = nk;
  endtask

  always @(negedge clk) begin
    if (bus.cmd_err) err_cnt++;
    if (stretch_left != 0)
      stretch_left--;
    else if (stretch_arm && prev_oe && !bus.scl_oe && oe_falls == 2) begin
      stretch_left = 50;
      stretch_arm  = 1'b0;
    end
    if (prev_oe && !bus.scl_oe) oe_falls++;
    prev_oe = bus.scl_oe;
    scl_now = ~bus.scl_oe & (stretch_left == 0);
    sda_now = ~bus.sda_oe & ~ack_en;
    if (!prev_scl && scl_now) begin
      seen_rise = 1'b1;
      if (bit_idx < 8) sh = {sh[6:0], sda_now};
      bit_idx++;
      if (bit_idx == 8 && rx_n < 8) begin
        rx[rx_n] = sh;
        rx_n++;
      end
    end else if (prev_scl && !scl_now) begin
      if (seen_rise) pulses++;
      seen_rise = 1'b0;
      if (bit_idx == 8)
        ack_en = ((rx_n - 1) != nack_byte);
      else if (bit_idx == 9) begin
        bit_idx = 0;
        ack_en  = 1'b0;
      end
    end
    prev_scl = scl_now;
  end

  task automatic run_cmd(input logic [36:0] cmd, input int nk, input logic arm,
                         input logic mid_strobe, output int busy_cycles);
    @(posedge clk);
    clear_mon(nk, arm);
    @(negedge clk);
    bus.i2ccmd   = cmd;
    bus.i2cstart = 1'b1;
    @(negedge clk);
    bus.i2cstart = 1'b0;
    busy_cycles  = 0;
    while (bus.i2cbusy && busy_cycles < 5000) begin
      busy_cycles++;
      if (mid_strobe && busy_cycles == 100) begin
        bus.i2cstart = 1'b1;
        bus.i2ccmd   = 37'h11_AA00_0000;
      end else begin
        bus.i2cstart = 1'b0;
      end
      @(negedge clk);
    end
    bus.i2cstart = 1'b0;
    check("done_pulse", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic bad_cmd(input string tag, input logic [36:0] cmd);
    logic oe_seen;
    @(negedge clk);
    bus.i2ccmd   = cmd;
    bus.i2cstart = 1'b1;
    @(negedge clk);
    bus.i2cstart = 1'b0;
    check({tag, "_err"},  {63'd0, bus.cmd_err}, 64'd1);
    check({tag, "_busy"}, {63'd0, bus.i2cbusy}, 64'd0);
    oe_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      oe_seen = oe_seen | bus.scl_oe | bus.sda_oe | bus.i2cbusy | bus.cmd_err;
    end
    check({tag, "_quiet"}, {63'd0, oe_seen}, 64'd0);
  endtask

  int bc;
  int e0;

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    err_cnt      = 0;
    rstn         = 1'b0;
    bus.i2ccmd   = 37'd0;
    bus.i2cstart = 1'b0;
    clear_mon(-1, 1'b0);

    repeat (3) @(negedge clk);
    check("reset_outs", {58'd0, bus.i2cbusy, bus.done, bus.nack, bus.cmd_err,
                         bus.scl_oe, bus.sda_oe}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 3-byte write, all ACKed
    run_cmd(37'h13_BA87_2000, -1, 1'b0, 1'b0, bc);
    check("a_busy",   bc, 468);
    check("a_nbytes", rx_n, 3);
    check("a_b0",     rx[0], 8'hBA);
    check("a_b1",     rx[1], 8'h87);
    check("a_b2",     rx[2], 8'h20);
    check("a_pulses", pulses, 27);
    check("a_nack",   {63'd0, bus.nack}, 64'd0);
    @(negedge clk);
    check("a_done_1cyc", {63'd0, bus.done}, 64'd0);

    // mux write with a stray strobe while busy
    @(posedge clk);
    e0 = err_cnt;
    run_cmd(37'h12_E801_0000, -1, 1'b0, 1'b1, bc);
    check("b_busy",   bc, 324);
    check("b_nbytes", rx_n, 2);
    check("b_b0",     rx[0], 8'hE8);
    check("b_b1",     rx[1], 8'h01);
    check("b_pulses", pulses, 18);
    @(posedge clk);
    check("b_no_err", err_cnt - e0, 0);
    repeat (20) @(negedge clk);
    check("b_ignored", {63'd0, bus.i2cbusy}, 64'd0);

    // NACK on byte 1 of 3
    run_cmd(37'h13_BA87_2000, 1, 1'b0, 1'b0, bc);
    check("n_busy",   bc, 324);
    check("n_nack",   {63'd0, bus.nack}, 64'd1);
    check("n_nbytes", rx_n, 2);
    check("n_b1",     rx[1], 8'h87);
    check("n_pulses", pulses, 18);

    // next good command clears nack
    run_cmd(37'h12_E801_0000, -1, 1'b0, 1'b0, bc);
    check("c_busy", bc, 324);
    check("c_nack", {63'd0, bus.nack}, 64'd0);

    // 50-cycle clock stretch after third bit release
    run_cmd(37'h12_E801_0000, -1, 1'b1, 1'b0, bc);
    check("s_busy", bc, 374);
    check("s_b0",   rx[0], 8'hE8);
    check("s_b1",   rx[1], 8'h01);

    // rejected strobes
    bad_cmd("n0",  37'h10_BA00_0000);
    bad_cmd("n5",  37'h15_BA00_0000);
    bad_cmd("inv", 37'h01_BA00_0000);

    // reset in the middle of the first byte
    @(posedge clk);
    clear_mon(-1, 1'b0);
    @(negedge clk);
    bus.i2ccmd   = 37'h13_BA87_2000;
    bus.i2cstart = 1'b1;
    @(negedge clk);
    bus.i2cstart = 1'b0;
    repeat (57) @(negedge clk);
    check("r_pre_busy", {62'd0, bus.i2cbusy, bus.scl_oe}, 64'd3);
    rstn = 1'b0;
    #1;
    check("r_async", {61'd0, bus.i2cbusy, bus.scl_oe, bus.sda_oe}, 64'd0);
    repeat (3) @(negedge clk);
    check("r_no_done", {62'd0, bus.done, bus.i2cbusy}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(37'h13_BA87_2000, -1, 1'b0, 1'b0, bc);
    check("r_busy",   bc, 468);
    check("r_nbytes", rx_n, 3);
    check("r_b2",     rx[2], 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
